// File: rtl/sync_conditioner.sv
// Sync conditioner: synchronizes and glitch-filters raw hsync/vsync, flags frame starts,
// measures the hsync line period and reports lock once the period is stable.
module sync_conditioner #(
  parameter int FILT_LEN   = 3,
  parameter int LINE_WIDTH = 8,
  parameter int TOL        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start,
  output logic [LINE_WIDTH-1:0] line_len,
  output logic                  line_valid,
  output logic                  locked
);

  localparam int                  FW        = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0]       FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [LINE_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [LINE_WIDTH:0] TOL_W     = (LINE_WIDTH + 1)'(TOL);
  localparam logic [2:0]          LOCK_RUN  = 3'd4;

  typedef enum logic [1:0] {SEEK, TRACK, LOCKED} state_t;

  // Channel 0 is hsync, channel 1 is vsync.
  logic [1:0]    raw;
  logic [1:0]    meta;
  logic [1:0]    synced;
  logic [1:0]    clean;
  logic [1:0]    flip;
  logic [FW-1:0] fcnt [2];

  assign raw   = {vsync_in, hsync_in};
  assign hsync = clean[0];
  assign vsync = clean[1];

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 2; i++) begin
      flip[i] = (synced[i] != clean[i]) && (fcnt[i] == FILT_LAST);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta        <= '1;
      synced      <= '1;
      clean       <= '1;
      fcnt[0]     <= '0;
      fcnt[1]     <= '0;
      frame_start <= 1'b0;
    end else begin
      meta        <= raw;
      synced      <= meta;
      frame_start <= flip[1] & clean[1];
      for (int i = 0; i < 2; i++) begin
        if (synced[i] == clean[i]) begin
          fcnt[i] <= '0;
        end else if (flip[i]) begin
          fcnt[i]  <= '0;
          clean[i] <= ~clean[i];
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  // Line period measurement from the clean hsync falling edge.
  logic                  h_prev;
  logic                  hfall;
  logic                  saturated;
  logic [LINE_WIDTH-1:0] cnt;

  assign hfall     = h_prev & ~clean[0];
  assign saturated = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_prev <= 1'b1;
      cnt    <= '0;
    end else begin
      h_prev <= clean[0];
      if (hfall) begin
        cnt <= LINE_WIDTH'(1);
      end else if (!saturated) begin
        cnt <= cnt + LINE_WIDTH'(1);
      end
    end
  end

  // Unsigned distance between this period and the previous one, one bit wider so it never wraps.
  logic [LINE_WIDTH:0] diff;
  logic                match;

  always_comb begin
    if (cnt >= line_len) begin
      diff = {1'b0, cnt} - {1'b0, line_len};
    end else begin
      diff = {1'b0, line_len} - {1'b0, cnt};
    end
    match = ref_valid && (diff <= TOL_W);
  end

  state_t                state, state_n;
  logic [2:0]            match_cnt, match_cnt_n;
  logic                  ref_valid, ref_valid_n;
  logic [LINE_WIDTH-1:0] line_len_n;
  logic                  line_valid_n;

  always_comb begin
    state_n      = state;
    match_cnt_n  = match_cnt;
    ref_valid_n  = ref_valid;
    line_len_n   = line_len;
    line_valid_n = 1'b0;
    if (hfall && (state == SEEK || saturated)) begin
      // A saturated count means the previous edge is stale: this edge restarts acquisition.
      state_n     = TRACK;
      ref_valid_n = 1'b0;
      match_cnt_n = '0;
    end else if (hfall) begin
      line_len_n   = cnt;
      line_valid_n = 1'b1;
      ref_valid_n  = 1'b1;
      if (state == LOCKED) begin
        if (!match) begin
          state_n     = TRACK;
          match_cnt_n = '0;
        end
      end else if (match) begin
        match_cnt_n = match_cnt + 3'd1;
        if (match_cnt == LOCK_RUN - 3'd1) begin
          state_n = LOCKED;
        end
      end else begin
        match_cnt_n = '0;
      end
    end else if (saturated) begin
      state_n     = SEEK;
      ref_valid_n = 1'b0;
      match_cnt_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEEK;
      match_cnt  <= '0;
      ref_valid  <= 1'b0;
      line_len   <= '0;
      line_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_n;
      match_cnt  <= match_cnt_n;
      ref_valid  <= ref_valid_n;
      line_len   <= line_len_n;
      line_valid <= line_valid_n;
      locked     <= (state_n == LOCKED);
    end
  end

endmodule

// File: tb/tb_sync_conditioner.sv
// Bench for sync_conditioner: directed sync scenarios plus randomized lines, with a
// period/lock reference model feeding a scoreboard drained on every line_valid.
module tb_sync_conditioner;

  localparam int FILT_LEN   = 3;
  localparam int LINE_WIDTH = 8;
  localparam int TOL        = 1;
  localparam int CNT_MAX    = (1 << LINE_WIDTH) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  hsync_in;
  logic                  vsync_in;
  logic                  hsync;
  logic                  vsync;
  logic                  frame_start;
  logic [LINE_WIDTH-1:0] line_len;
  logic                  line_valid;
  logic                  locked;

  sync_conditioner #(
    .FILT_LEN  (FILT_LEN),
    .LINE_WIDTH(LINE_WIDTH),
    .TOL       (TOL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start),
    .line_len   (line_len),
    .line_valid (line_valid),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int fs_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: actual %0d, expected %0d", name, actual, expected);
  endtask

  // Scoreboard entries: line length reported and lock status right after that line.
  typedef struct packed {
    logic [LINE_WIDTH-1:0] len;
    logic                  lk;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: works on time between raw hsync falls, which the fixed filter delay preserves.
  bit m_seek;
  bit m_have_ref;
  bit m_lk;
  int m_ref;
  int m_run;
  int m_last;

  task automatic model_reset();
    m_seek     = 1'b1;
    m_have_ref = 1'b0;
    m_lk       = 1'b0;
    m_ref      = 0;
    m_run      = 0;
    m_last     = 0;
  endtask

  task automatic model_fall(input int now);
    int   p;
    bit   m;
    exp_t e;
    p = now - m_last;
    if (m_seek || p >= CNT_MAX) begin
      m_seek     = 1'b0;
      m_have_ref = 1'b0;
      m_run      = 0;
      m_lk       = 1'b0;
    end else begin
      m          = m_have_ref && (p - m_ref <= TOL) && (m_ref - p <= TOL);
      m_have_ref = 1'b1;
      m_ref      = p;
      if (m_lk) begin
        if (!m) begin
          m_lk  = 1'b0;
          m_run = 0;
        end
      end else if (m) begin
        m_run++;
        if (m_run >= 4) m_lk = 1'b1;
      end else begin
        m_run = 0;
      end
      e.len = LINE_WIDTH'(p);
      e.lk  = m_lk;
      sb_q.push_back(e);
    end
    m_last = now;
  endtask

  // Monitor: sampled on the falling edge, away from the edge that updates outputs.
  always @(negedge clk) begin
    exp_t e;
    if (frame_start) fs_cnt++;
    if (line_valid) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_line_valid: actual line_len %0d, expected no line_valid", line_len);
      end else begin
        e = sb_q.pop_front();
        check("line_len", int'(line_len), int'(e.len));
        check("locked_at_line_valid", int'(locked), int'(e.lk));
      end
    end
  end

  // All stimulus tasks start and end just after a falling clock edge.
  task automatic line(input int lo, input int hi, input bit glitch);
    int g;
    hsync_in = 1'b0;
    model_fall(cyc);
    repeat (lo) @(negedge clk);
    hsync_in = 1'b1;
    if (glitch && hi >= 14) begin
      g = int'($urandom_range(1, FILT_LEN - 1));
      repeat (5) @(negedge clk);
      hsync_in = 1'b0;
      repeat (g) @(negedge clk);
      hsync_in = 1'b1;
      repeat (hi - 5 - g) @(negedge clk);
    end else begin
      repeat (hi) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    check("scoreboard_empty_at_reset", sb_q.size(), 0);
    sb_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int fs0;
    bit seen_low;
    int lo;
    int per;
    int r;

    rst      = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    model_reset();
    #1;
    check("reset_hsync", hsync, 1);
    check("reset_vsync", vsync, 1);
    check("reset_frame_start", frame_start, 0);
    check("reset_line_valid", line_valid, 0);
    check("reset_locked", locked, 0);
    check("reset_line_len", line_len, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Two-clock glitch must be swallowed by the filter.
    repeat (5) @(negedge clk);
    hsync_in = 1'b0;
    repeat (2) @(negedge clk);
    hsync_in = 1'b1;
    seen_low = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (!hsync) seen_low = 1'b1;
    end
    check("glitch_hsync_low_seen", seen_low, 0);

    // Raw to clean latency on hsync.
    hsync_in = 1'b0;
    model_fall(cyc);
    k = 0;
    while (hsync && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("hsync_fall_latency", k, 2 + FILT_LEN);
    @(negedge clk);
    repeat (6) @(negedge clk);
    hsync_in = 1'b1;
    repeat (10) @(negedge clk);

    // Raw to clean latency on vsync, with a single frame_start.
    fs0      = fs_cnt;
    vsync_in = 1'b0;
    k = 0;
    while (vsync && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("vsync_fall_latency", k, 2 + FILT_LEN);
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("frame_start_pulses", fs_cnt - fs0, 1);
    vsync_in = 1'b1;
    repeat (12) @(negedge clk);
    check("frame_start_after_vsync_rise", fs_cnt - fs0, 1);

    // Acquire lock on 40-clock lines.
    do_reset();
    repeat (5) @(negedge clk);
    repeat (7) line(8, 32, 1'b0);
    check("locked_after_stable_lines", locked, 1);

    // One long line breaks lock; four more matches restore it.
    line(8, 36, 1'b0);
    repeat (6) line(8, 32, 1'b0);
    check("relocked_after_long_line", locked, 1);

    // Saturation: hsync held high long enough for the period counter to max out.
    repeat (300) @(negedge clk);
    check("sat_cnt", int'(dut.cnt), CNT_MAX);
    check("sat_locked", locked, 0);
    check("sat_line_len_kept", line_len, 40);
    repeat (7) line(8, 32, 1'b0);
    check("locked_after_saturation", locked, 1);

    // Asynchronous reset between clock edges, mid-line while locked.
    hsync_in = 1'b0;
    model_fall(cyc);
    repeat (8) @(negedge clk);
    hsync_in = 1'b1;
    repeat (12) @(negedge clk);
    check("scoreboard_empty_before_async_reset", sb_q.size(), 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_locked", locked, 0);
    check("async_rst_line_len", line_len, 0);
    check("async_rst_line_valid", line_valid, 0);
    check("async_rst_hsync", hsync, 1);
    check("async_rst_vsync", vsync, 1);
    check("async_rst_frame_start", frame_start, 0);
    @(negedge clk);
    sb_q.delete();
    model_reset();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    repeat (5) line(8, 32, 1'b0);
    check("not_locked_after_5_fresh_hfalls", locked, 0);
    repeat (2) line(8, 32, 1'b0);
    check("locked_after_fresh_hfalls", locked, 1);

    // Randomized lines: jitter, mismatches, stale gaps, short glitches and vsync activity.
    for (int n = 0; n < 80; n++) begin
      lo = int'($urandom_range(FILT_LEN, 10));
      r  = int'($urandom_range(0, 15));
      if (r < 10)       per = 40 + int'($urandom_range(0, 2)) - 1;
      else if (r < 13)  per = 40 + int'($urandom_range(4, 6));
      else if (r < 15)  per = int'($urandom_range(100, 250));
      else              per = int'($urandom_range(256, 280));
      if ($urandom_range(0, 3) == 0) vsync_in = ~vsync_in;
      line(lo, per - lo, ($urandom_range(0, 2) == 0));
    end
    repeat (20) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
